// File: rtl/asr.sv
// Addressable shift register: tapped delay line with random-access read of any stage.
// Define ASR_REG_OUT_EN to register dataout (one clock read latency).
module asr #(
  parameter int unsigned N      = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N-1:0]      q,
  input  logic [ADDR_W-1:0] addr,
  output logic [N-1:0]      dataout
);

  logic [N-1:0] stage_q [DEPTH];
  logic [N-1:0] stage_d [DEPTH];

  // Shift/hold only; reset is applied in the register block.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (enable) begin
      stage_d[0] = q;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // Mux by address match so an addr >= DEPTH selects nothing and yields 0, never X.
  function automatic logic [N-1:0] sel(input logic [N-1:0] st [DEPTH],
                                       input logic [ADDR_W-1:0] a);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == ADDR_W'(i)) begin
        r = st[i];
      end
    end
    return r;
  endfunction

`ifdef ASR_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dataout <= '0;
    end else begin
      dataout <= sel(stage_d, addr);
    end
  end
`else
  always_comb begin
    dataout = sel(stage_q, addr);
  end
`endif

endmodule

// File: tb/tb_asr.sv
// Directed self-checking bench for asr; a second DEPTH=10 instance covers out-of-range addresses.
module tb_asr;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] q;
  logic [3:0] addr;
  logic [3:0] addr2;
  logic [7:0] dataout;
  logic [7:0] dataout2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  asr #(.N(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .q       (q),
    .addr    (addr),
    .dataout (dataout)
  );

  asr #(.N(8), .DEPTH(10), .ADDR_W(4)) dut10 (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .q       (q),
    .addr    (addr2),
    .dataout (dataout2)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Make the current addr visible on dataout; caller holds enable low.
  task automatic settle();
`ifdef ASR_REG_OUT_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic check_stage(input string tag, input int a, input logic [7:0] exp);
    addr = 4'(a);
    settle();
    check($sformatf("%s[%0d]", tag, a), dataout, exp);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    q      = '0;
    addr   = '0;
    addr2  = '0;
    tick();
    reset = 1'b0;

    // 1: load nonzero data, then a single reset edge clears everything
    enable = 1'b1;
    q = 8'h77;
    repeat (3) tick();
    enable = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 16; a++) check_stage("reset", a, 8'h00);

    // 2: shift and sample age
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      q = 8'(k);
      tick();
    end
    enable = 1'b0;
    for (int a = 0; a < 16; a++) check_stage("shift", a, (a < 4) ? 8'(4 - a) : 8'h00);

    // 3: hold while q changes
    q = 8'hAA;
    repeat (5) tick();
    for (int a = 0; a < 16; a++) check_stage("hold", a, (a < 4) ? 8'(4 - a) : 8'h00);

    // 4: wrap-out, oldest samples fall off the end
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      q = 8'(k);
      tick();
    end
    enable = 1'b0;
    for (int a = 0; a < 16; a++) check_stage("wrap", a, 8'(20 - a));

    // DEPTH=10 instance: in-range tap, then addresses beyond its last stage
    addr2 = 4'd9;
    settle();
    check("d10_addr9", dataout2, 8'd11);
    addr2 = 4'd12;
    settle();
    check("d10_addr12", dataout2, 8'h00);
    addr2 = 4'd15;
    settle();
    check("d10_addr15", dataout2, 8'h00);

    // 5: reset wins over a simultaneous enable
    reset  = 1'b1;
    enable = 1'b1;
    q      = 8'd9;
    tick();
    reset  = 1'b0;
    enable = 1'b0;
    for (int a = 0; a < 16; a++) check_stage("midrst", a, 8'h00);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check_stage("after_rst", 0, 8'd9);
    check_stage("after_rst", 1, 8'h00);

    // 6: read timing
    addr = 4'd0;
    settle();
    check("rd_a0", dataout, 8'd9);
    addr = 4'd1;
    #1;
`ifdef ASR_REG_OUT_EN
    check("rd_lat_before", dataout, 8'd9);
    tick();
    check("rd_lat_after", dataout, 8'h00);
`else
    check("rd_same_cycle", dataout, 8'h00);
`endif
    enable = 1'b1;
    q      = 8'h33;
    addr   = 4'd0;
    tick();
    enable = 1'b0;
    check("shift_and_read", dataout, 8'h33);
    addr = 4'd1;
    settle();
    check("shift_and_read_a1", dataout, 8'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
